// File: rtl/pht_ctrl_pkg.sv
// Shared constants for the branch pattern history table controller.
// Default table index width, 2-bit counter encodings and FSM state encoding.
// Imported by the controller and by the saturating counter it instantiates.
package pht_ctrl_pkg;

  localparam int PHT_IDX_W = 13;

  // 2-bit saturating counter encodings; bit 1 is the taken prediction
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    S_SWEEP = 1'b0,
    S_IDLE  = 1'b1
  } pht_state_e;

endpackage

// File: rtl/pht_sat_counter.sv
// Next state of a 2-bit saturating branch counter.
// Purely combinational, zero latency.
// No flow control: output follows the inputs every cycle.
module pht_sat_counter
  import pht_ctrl_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic       i_taken,
  output logic [1:0] o_next
);

  // Move one step toward the observed outcome, saturating at both ends
  always_comb begin
    o_next = i_state;
    if (i_taken) begin
      if (i_state != CTR_ST) o_next = i_state + 2'd1;
    end else begin
      if (i_state != CTR_SNT) o_next = i_state - 2'd1;
    end
  end

endmodule

// File: rtl/pht_ctrl.sv
// Owns the PHT write port: init sweep after reset/flush, else EX counter updates.
// Writes take effect in the request cycle; pred_state is valid one cycle after rd_en.
// Updates arriving during a sweep, or together with a flush, are dropped (no stall).
module pht_ctrl
  import pht_ctrl_pkg::*;
#(
  parameter int         IDX_W      = PHT_IDX_W,
  parameter logic [1:0] INIT_STATE = CTR_SNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_index,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  input  logic [1:0]       upd_state,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_waddr,
  output logic [1:0]       tbl_wdata,
  output logic             tbl_re,
  output logic [IDX_W-1:0] tbl_raddr,
  input  logic [1:0]       tbl_rdata,
  output logic [1:0]       pred_state,
  output logic             busy,
  output logic [31:0]      cnt_branch,
  output logic [31:0]      cnt_miss
);

  localparam logic [IDX_W-1:0] SC_LAST = '1;

  pht_state_e       r_state;
  pht_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_sc;
  logic [IDX_W-1:0] w_sc_nxt;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [1:0]       w_wdata;
  logic [1:0]       w_sat_next;
  logic             w_cnt_en;
  logic             w_busy;
  logic             r_busy_d;
  logic             r_hit;
  logic [1:0]       r_byp_dat;
  logic [31:0]      r_cnt_branch;
  logic [31:0]      r_cnt_miss;

  pht_sat_counter u_sat (
    .i_state (upd_state),
    .i_taken (upd_taken),
    .o_next  (w_sat_next)
  );

  // FSM state and sweep counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_SWEEP;
      r_sc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
    end
  end

  // Next state and write-port mux; a flush always wins over the update
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_we        = 1'b0;
    w_waddr     = upd_index;
    w_wdata     = w_sat_next;
    w_cnt_en    = 1'b0;
    case (r_state)
      S_SWEEP: begin
        w_we    = 1'b1;
        w_waddr = r_sc;
        w_wdata = INIT_STATE;
        if (flush_req) begin
          w_sc_nxt = '0;
        end else begin
          w_sc_nxt = r_sc + IDX_W'(1);
          if (r_sc == SC_LAST) w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (flush_req) begin
          w_state_nxt = S_SWEEP;
          w_sc_nxt    = '0;
        end else begin
          w_we     = upd_valid;
          w_cnt_en = upd_valid;
        end
      end
    endcase
  end

  assign w_busy    = (r_state == S_SWEEP);
  assign busy      = w_busy;
  // The reset state is SWEEP, so hold the write enable off while reset is asserted
  assign tbl_we    = w_we & rst;
  assign tbl_waddr = w_waddr;
  assign tbl_wdata = w_wdata;
  assign tbl_re    = rd_en;
  assign tbl_raddr = rd_index;

  // Branch/mispredict statistics; a flush clears them in any state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_branch <= '0;
      r_cnt_miss   <= '0;
    end else if (flush_req) begin
      r_cnt_branch <= '0;
      r_cnt_miss   <= '0;
    end else if (w_cnt_en) begin
      r_cnt_branch <= r_cnt_branch + 32'd1;
      if (upd_state[1] != upd_taken) r_cnt_miss <= r_cnt_miss + 32'd1;
    end
  end

  assign cnt_branch = r_cnt_branch;
  assign cnt_miss   = r_cnt_miss;

  // Capture same-cycle write data when the lookup hits the address being written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit     <= 1'b0;
      r_byp_dat <= INIT_STATE;
    end else if (rd_en) begin
      r_hit     <= w_we && (rd_index == w_waddr);
      r_byp_dat <= w_wdata;
    end
  end

  // Delayed busy covers the read issued in the final sweep cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy_d <= 1'b1;
    else      r_busy_d <= w_busy;
  end

  assign pred_state = (w_busy || r_busy_d) ? INIT_STATE :
                      (r_hit ? r_byp_dat : tbl_rdata);

endmodule

// File: tb/tb_pht_ctrl.sv
// Directed bench for pht_ctrl with a 16-entry table and a behavioural RAM.
// Inputs change at negedge+1; outputs are sampled #1 after a negedge.
// Covers reset sweep, updates, saturation, bypass, flush and mid-sweep flush.
module tb_pht_ctrl;

  logic       clk;
  logic       rst;
  logic       flush_req;
  logic       rd_en;
  logic [3:0] rd_index;
  logic       upd_valid;
  logic [3:0] upd_index;
  logic       upd_taken;
  logic [1:0] upd_state;
  logic       tbl_we;
  logic [3:0] tbl_waddr;
  logic [1:0] tbl_wdata;
  logic       tbl_re;
  logic [3:0] tbl_raddr;
  logic [1:0] tbl_rdata;
  logic [1:0] pred_state;
  logic       busy;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_miss;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  idx;
    logic [1:0]  st;
    logic        tk;
    logic [1:0]  wd;
    int unsigned br;
    int unsigned ms;
  } upd_vec_t;

  logic [1:0] mem [16];

  pht_ctrl #(.IDX_W(4), .INIT_STATE(2'b00)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_req  (flush_req),
    .rd_en      (rd_en),
    .rd_index   (rd_index),
    .upd_valid  (upd_valid),
    .upd_index  (upd_index),
    .upd_taken  (upd_taken),
    .upd_state  (upd_state),
    .tbl_we     (tbl_we),
    .tbl_waddr  (tbl_waddr),
    .tbl_wdata  (tbl_wdata),
    .tbl_re     (tbl_re),
    .tbl_raddr  (tbl_raddr),
    .tbl_rdata  (tbl_rdata),
    .pred_state (pred_state),
    .busy       (busy),
    .cnt_branch (cnt_branch),
    .cnt_miss   (cnt_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous table RAM: read returns the pre-write contents
  always @(posedge clk) begin
    if (tbl_re) tbl_rdata <= mem[tbl_raddr];
    if (tbl_we) mem[tbl_waddr] <= tbl_wdata;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_req = 1'b0; rd_en = 1'b0; rd_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; upd_state = '0;
    tbl_rdata = 2'b11;
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;
    step(); step();
    n_cmp++; if (tbl_we !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b exp=0", tbl_we); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy got=%b exp=1", busy); end
    n_cmp++; if (pred_state !== 2'b00) begin n_err++; $display("FAIL rst_pred got=%b exp=00", pred_state); end
    n_cmp++; if (cnt_branch !== 32'd0) begin n_err++; $display("FAIL rst_cnt_branch got=%0d exp=0", cnt_branch); end
    n_cmp++; if (cnt_miss !== 32'd0) begin n_err++; $display("FAIL rst_cnt_miss got=%0d exp=0", cnt_miss); end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (tbl_we !== 1'b1) begin n_err++; $display("FAIL sweep_we[%0d] got=%b exp=1", i, tbl_we); end
      n_cmp++; if (tbl_waddr !== 4'(i)) begin n_err++; $display("FAIL sweep_addr[%0d] got=%0d exp=%0d", i, tbl_waddr, i); end
      n_cmp++; if (tbl_wdata !== 2'b00) begin n_err++; $display("FAIL sweep_data[%0d] got=%b exp=00", i, tbl_wdata); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy[%0d] got=%b exp=1", i, busy); end
      step();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_update();
    upd_vec_t v [6];
    v[0] = '{4'd5,  2'b01, 1'b1, 2'b10, 1, 1};
    v[1] = '{4'd6,  2'b11, 1'b1, 2'b11, 2, 1};
    v[2] = '{4'd8,  2'b00, 1'b0, 2'b00, 3, 1};
    v[3] = '{4'd9,  2'b11, 1'b1, 2'b11, 4, 1};
    v[4] = '{4'd10, 2'b10, 1'b0, 2'b01, 5, 2};
    v[5] = '{4'd11, 2'b01, 1'b0, 2'b00, 6, 2};
    for (int i = 0; i < 6; i++) begin
      upd_valid = 1'b1; upd_index = v[i].idx; upd_state = v[i].st; upd_taken = v[i].tk;
      #1;
      n_cmp++; if (tbl_we !== 1'b1) begin n_err++; $display("FAIL upd_we[%0d] got=%b exp=1", i, tbl_we); end
      n_cmp++; if (tbl_waddr !== v[i].idx) begin n_err++; $display("FAIL upd_addr[%0d] got=%0d exp=%0d", i, tbl_waddr, v[i].idx); end
      n_cmp++; if (tbl_wdata !== v[i].wd) begin n_err++; $display("FAIL upd_data[%0d] got=%b exp=%b", i, tbl_wdata, v[i].wd); end
      step();
      upd_valid = 1'b0;
      #1;
      n_cmp++; if (tbl_we !== 1'b0) begin n_err++; $display("FAIL upd_idle_we[%0d] got=%b exp=0", i, tbl_we); end
      n_cmp++; if (cnt_branch !== v[i].br) begin n_err++; $display("FAIL upd_cnt_branch[%0d] got=%0d exp=%0d", i, cnt_branch, v[i].br); end
      n_cmp++; if (cnt_miss !== v[i].ms) begin n_err++; $display("FAIL upd_cnt_miss[%0d] got=%0d exp=%0d", i, cnt_miss, v[i].ms); end
    end
  endtask

  task automatic test_bypass();
    rd_en = 1'b1; rd_index = 4'd7;
    upd_valid = 1'b1; upd_index = 4'd7; upd_state = 2'b10; upd_taken = 1'b1;
    #1;
    n_cmp++; if (tbl_re !== 1'b1 || tbl_raddr !== 4'd7) begin n_err++; $display("FAIL byp_read got=%b/%0d exp=1/7", tbl_re, tbl_raddr); end
    n_cmp++; if (tbl_we !== 1'b1 || tbl_wdata !== 2'b11) begin n_err++; $display("FAIL byp_write got=%b/%b exp=1/11", tbl_we, tbl_wdata); end
    step();
    upd_valid = 1'b0;
    n_cmp++; if (pred_state !== 2'b11) begin n_err++; $display("FAIL byp_pred got=%b exp=11", pred_state); end
    n_cmp++; if (cnt_branch !== 32'd7 || cnt_miss !== 32'd2) begin n_err++; $display("FAIL byp_cnt got=%0d/%0d exp=7/2", cnt_branch, cnt_miss); end
    step();
    n_cmp++; if (pred_state !== 2'b11) begin n_err++; $display("FAIL ram_pred7 got=%b exp=11", pred_state); end
    rd_index = 4'd5;
    step();
    n_cmp++; if (pred_state !== 2'b10) begin n_err++; $display("FAIL ram_pred5 got=%b exp=10", pred_state); end
    rd_en = 1'b0; rd_index = 4'd7;
    step();
    n_cmp++; if (pred_state !== 2'b10) begin n_err++; $display("FAIL pred_hold got=%b exp=10", pred_state); end
  endtask

  task automatic test_flush();
    upd_vec_t v [3];
    v[0] = '{4'd1, 2'b00, 1'b1, 2'b01, 8,  3};
    v[1] = '{4'd2, 2'b11, 1'b1, 2'b11, 9,  3};
    v[2] = '{4'd3, 2'b11, 1'b1, 2'b11, 10, 3};
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_index = v[i].idx; upd_state = v[i].st; upd_taken = v[i].tk;
      #1;
      n_cmp++; if (tbl_wdata !== v[i].wd) begin n_err++; $display("FAIL pre_data[%0d] got=%b exp=%b", i, tbl_wdata, v[i].wd); end
      step();
      upd_valid = 1'b0;
      n_cmp++; if (cnt_branch !== v[i].br || cnt_miss !== v[i].ms) begin n_err++; $display("FAIL pre_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, cnt_branch, cnt_miss, v[i].br, v[i].ms); end
    end
    flush_req = 1'b1;
    upd_valid = 1'b1; upd_index = 4'd9; upd_state = 2'b01; upd_taken = 1'b1;
    #1;
    n_cmp++; if (tbl_we !== 1'b0) begin n_err++; $display("FAIL flush_upd_we got=%b exp=0", tbl_we); end
    step();
    flush_req = 1'b0;
    upd_index = 4'd12;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy got=%b exp=1", busy); end
    n_cmp++; if (tbl_we !== 1'b1 || tbl_waddr !== 4'd0 || tbl_wdata !== 2'b00) begin n_err++; $display("FAIL flush_w0 got=%b/%0d/%b exp=1/0/00", tbl_we, tbl_waddr, tbl_wdata); end
    n_cmp++; if (cnt_branch !== 32'd0 || cnt_miss !== 32'd0) begin n_err++; $display("FAIL flush_cnt got=%0d/%0d exp=0/0", cnt_branch, cnt_miss); end
    step();
    n_cmp++; if (tbl_waddr !== 4'd1 || tbl_wdata !== 2'b00) begin n_err++; $display("FAIL sweep_upd_addr got=%0d/%b exp=1/00", tbl_waddr, tbl_wdata); end
    n_cmp++; if (cnt_branch !== 32'd0 || cnt_miss !== 32'd0) begin n_err++; $display("FAIL sweep_upd_cnt got=%0d/%0d exp=0/0", cnt_branch, cnt_miss); end
    upd_valid = 1'b0;
  endtask

  task automatic test_flush_mid();
    repeat (8) step();
    n_cmp++; if (tbl_waddr !== 4'd9) begin n_err++; $display("FAIL mid_sc9 got=%0d exp=9", tbl_waddr); end
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #1;
    for (int j = 0; j < 16; j++) begin
      n_cmp++; if (busy !== 1'b1 || tbl_waddr !== 4'(j)) begin n_err++; $display("FAIL mid_sweep[%0d] got=%b/%0d exp=1/%0d", j, busy, tbl_waddr, j); end
      step();
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_done_busy got=%b exp=0", busy); end
  endtask

  task automatic test_after_sweep();
    upd_valid = 1'b1; upd_index = 4'd4; upd_state = 2'b01; upd_taken = 1'b1;
    #1;
    n_cmp++; if (tbl_we !== 1'b1 || tbl_waddr !== 4'd4 || tbl_wdata !== 2'b10) begin n_err++; $display("FAIL post_write got=%b/%0d/%b exp=1/4/10", tbl_we, tbl_waddr, tbl_wdata); end
    step();
    upd_valid = 1'b0;
    n_cmp++; if (cnt_branch !== 32'd1 || cnt_miss !== 32'd1) begin n_err++; $display("FAIL post_cnt got=%0d/%0d exp=1/1", cnt_branch, cnt_miss); end
  endtask

  initial begin
    test_reset();
    test_update();
    test_bypass();
    test_flush();
    test_flush_mid();
    test_after_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
